// File: rtl/data_sync_tx_ctrl_if.sv
// Requester, synchronizer and status signals around the source-domain transfer controller.
// The master modport is the controller side; the slave modport is its environment.
interface data_sync_tx_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      unsync_bus;
    logic                  bus_enable;
    logic                  dest_ack;
    logic                  busy;
    logic                  timeout_err;
    logic                  err_clr;

    modport master (
        input  req,
        input  req_data,
        input  dest_ack,
        input  err_clr,
        output grant,
        output done,
        output unsync_bus,
        output bus_enable,
        output busy,
        output timeout_err
    );

    modport slave (
        output req,
        output req_data,
        output dest_ack,
        output err_clr,
        input  grant,
        input  done,
        input  unsync_bus,
        input  bus_enable,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/data_sync_tx_ctrl.sv
// Source-domain transfer controller: round-robin arbitration of NREQ requesters onto one
// synchronizer channel, 4-phase handshake against a synchronized dest_ack, with timeout abort.
module data_sync_tx_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int STAGES  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                RST,
    data_sync_tx_ctrl_if.master bus_if
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_ACK,
        WAIT_REL,
        RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] ack_sync_q;
    logic              ack_s;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     sel_q, sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  bus_q, bus_d;
    logic              en_q, en_d;
    logic              err_q, err_d;

    logic [PW-1:0]     lo_sel, hi_sel, pick;
    logic              hi_found;
    logic [WIDTH-1:0]  pick_word;
    logic              any_req;
    logic              tmo;

    // NOTE: every register here resets asynchronously on RST low, so bus_enable and the
    // status outputs fall the moment reset asserts rather than on the next CLK edge.
    // NOTE: sequential state uses non-blocking assignments only, so all flops sample the
    // values from before the edge regardless of process ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[STAGES-2:0], bus_if.dest_ack};
        end
    end

    assign ack_s = ack_sync_q[STAGES-1];

    // First request at or above the pointer wins; otherwise the lowest request (wrap).
    // NOTE: each combinational output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hi_found  = 1'b0;
        hi_sel    = '0;
        lo_sel    = '0;
        pick_word = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus_if.req[i]) begin
                lo_sel = PW'(i);
                if (i >= int'(ptr_q)) begin
                    hi_sel   = PW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick = hi_found ? hi_sel : lo_sel;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PW'(i)) begin
                pick_word = bus_if.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_req = |bus_if.req;
    assign tmo     = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = '0;
        grant_d = '0;
        done_d  = '0;
        bus_d   = bus_q;
        en_d    = en_q;
        // A timeout on the same edge overrides the clear below.
        err_d   = bus_if.err_clr ? 1'b0 : err_q;

        case (state_q)
            IDLE: begin
                if (any_req && !ack_s) begin
                    sel_d   = pick;
                    bus_d   = pick_word;
                    grant_d = NREQ'(1) << pick;
                    ptr_d   = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                en_d    = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    en_d    = 1'b0;
                    state_d = WAIT_REL;
                end else if (tmo) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!ack_s) begin
                    done_d  = NREQ'(1) << sel_q;
                    state_d = IDLE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign bus_if.grant       = grant_q;
    assign bus_if.done        = done_q;
    assign bus_if.unsync_bus  = bus_q;
    assign bus_if.bus_enable  = en_q;
    assign bus_if.busy        = (state_q != IDLE);
    assign bus_if.timeout_err = err_q;
endmodule
